// File: rtl/sound_pkg.sv
// Shared constants for the sound generator channels: register map, field
// positions and datapath widths.
package sound_pkg;
   localparam int PERIOD_W  = 11;
   localparam int PHASE_W   = 5;
   localparam int LEN_W     = 6;
   localparam int LEN_CNT_W = LEN_W + 1;

   localparam logic [1:0] REG_PERIOD_LO = 2'd0;
   localparam logic [1:0] REG_CTRL      = 2'd1;
   localparam logic [1:0] REG_LEN       = 2'd2;
   localparam logic [1:0] REG_SWEEP     = 2'd3;

   localparam int CTRL_TRIG_BIT   = 7;
   localparam int CTRL_LEN_EN_BIT = 6;
   localparam int CTRL_WAVE_LSB   = 3;
   localparam int CTRL_PHI_LSB    = 0;
   localparam int SWEEP_DIR_BIT   = 3;
   localparam int SWEEP_SHIFT_LSB = 0;
endpackage

// File: rtl/tone_sweep_calc.sv
// Frequency sweep arithmetic: period +/- (period >> shift), flagging an
// upward sweep that leaves the period range.
module tone_sweep_calc
   import sound_pkg::*;
(
   input  logic [PERIOD_W-1:0] i_period,
   input  logic [2:0]          i_shift,
   input  logic                i_dir,
   output logic [PERIOD_W-1:0] o_next_period,
   output logic                o_overflow
);
   logic [PERIOD_W-1:0] w_delta;
   logic [PERIOD_W:0]   w_sum;

   assign w_delta = i_period >> i_shift;
   assign w_sum   = {1'b0, i_period} + {1'b0, w_delta};

   // Subtracting period>>shift from period can never go negative.
   always_comb begin
      o_next_period = w_sum[PERIOD_W-1:0];
      o_overflow    = w_sum[PERIOD_W];
      if (i_dir) begin
         o_next_period = i_period - w_delta;
         o_overflow    = 1'b0;
      end
   end
endmodule

// File: rtl/tone_phase_gen.sv
// Tone channel: register file, period divider, 5-bit phase stepper, and
// frame-clocked length counter / sweep that gate the channel.
module tone_phase_gen
   import sound_pkg::*;
(
   input  logic               clk_in,
   input  logic               reset_n_in,
   input  logic               tick_in,
   input  logic               frame_tick_in,
   input  logic               reg_write_en_in,
   input  logic [1:0]         reg_addr_in,
   input  logic [7:0]         reg_data_in,
   output logic [PHASE_W-1:0] lut_addr_out,
   output logic [2:0]         wave_type_out,
   output logic               active_out,
   output logic               phase_wrap_out
);
   logic [PERIOD_W-1:0]  r_period;
   logic [PERIOD_W-1:0]  r_div_cnt;
   logic [LEN_CNT_W-1:0] r_len_cnt;
   logic                 r_len_en;
   logic                 r_sweep_dir;
   logic [2:0]           r_sweep_shift;

   logic                 w_wr_lo, w_wr_ctrl, w_wr_len, w_wr_sweep, w_trig;
   logic                 w_sweep_go, w_len_go, w_len_expire, w_ovf;
   logic [PERIOD_W-1:0]  w_wr_period, w_sweep_period;
   logic [LEN_CNT_W-1:0] w_len_after;

   assign w_wr_lo    = reg_write_en_in && (reg_addr_in == REG_PERIOD_LO);
   assign w_wr_ctrl  = reg_write_en_in && (reg_addr_in == REG_CTRL);
   assign w_wr_len   = reg_write_en_in && (reg_addr_in == REG_LEN);
   assign w_wr_sweep = reg_write_en_in && (reg_addr_in == REG_SWEEP);
   assign w_trig     = w_wr_ctrl && reg_data_in[CTRL_TRIG_BIT];

   assign w_sweep_go   = frame_tick_in && active_out && (r_sweep_shift != 3'd0);
   assign w_len_go     = frame_tick_in && active_out && r_len_en && (r_len_cnt != '0);
   assign w_len_expire = w_len_go && (r_len_cnt == LEN_CNT_W'(1));
   assign w_len_after  = w_len_go ? r_len_cnt - LEN_CNT_W'(1) : r_len_cnt;

   // Period as it stands after this cycle's register writes; a trigger
   // reloads the divider from this same-write value.
   always_comb begin
      w_wr_period = r_period;
      if (w_wr_lo)   w_wr_period[7:0] = reg_data_in;
      if (w_wr_ctrl) w_wr_period[PERIOD_W-1:8] = reg_data_in[CTRL_PHI_LSB +: 3];
   end

   tone_sweep_calc u_sweep (
      .i_period      (r_period),
      .i_shift       (r_sweep_shift),
      .i_dir         (r_sweep_dir),
      .o_next_period (w_sweep_period),
      .o_overflow    (w_ovf)
   );

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_period       <= '0;
         r_div_cnt      <= '0;
         r_len_cnt      <= '0;
         r_len_en       <= 1'b0;
         r_sweep_dir    <= 1'b0;
         r_sweep_shift  <= '0;
         lut_addr_out   <= '0;
         wave_type_out  <= '0;
         active_out     <= 1'b0;
         phase_wrap_out <= 1'b0;
      end else begin
         phase_wrap_out <= 1'b0;

         if (w_wr_lo || w_wr_ctrl)      r_period <= w_wr_period;
         else if (w_sweep_go && !w_ovf) r_period <= w_sweep_period;

         if (w_wr_ctrl) begin
            r_len_en      <= reg_data_in[CTRL_LEN_EN_BIT];
            wave_type_out <= reg_data_in[CTRL_WAVE_LSB +: 3];
         end
         if (w_wr_sweep) begin
            r_sweep_dir   <= reg_data_in[SWEEP_DIR_BIT];
            r_sweep_shift <= reg_data_in[SWEEP_SHIFT_LSB +: 3];
         end

         if (w_wr_len)
            r_len_cnt <= LEN_CNT_W'(64) - {1'b0, reg_data_in[LEN_W-1:0]};
         else if (w_trig && (w_len_after == '0))
            r_len_cnt <= LEN_CNT_W'(64);
         else
            r_len_cnt <= w_len_after;

         if (w_trig)
            active_out <= 1'b1;
         else if (w_len_expire || (w_sweep_go && w_ovf))
            active_out <= 1'b0;

         // Trigger wins over a coincident tick: restart without stepping.
         if (w_trig) begin
            lut_addr_out <= '0;
            r_div_cnt    <= w_wr_period;
         end else if (tick_in && active_out) begin
            if (r_div_cnt == '0) begin
               r_div_cnt      <= r_period;
               lut_addr_out   <= lut_addr_out + PHASE_W'(1);
               phase_wrap_out <= (lut_addr_out == '1);
            end else begin
               r_div_cnt <= r_div_cnt - PERIOD_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_tone_phase_gen.sv
// Randomised + directed bench for tone_phase_gen: a frequency-level model
// predicts outputs per cycle into a queue; a monitor pops and compares.
module tb_tone_phase_gen;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, ftick = 1'b0, we = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] data = '0;
   logic [4:0] lut;
   logic [2:0] wave;
   logic       act, wrap;

   typedef struct packed {
      logic [4:0] lut;
      logic [2:0] wave;
      logic       act;
      logic       wrap;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;

   // reference model state
   int m_per, m_wt, m_len_en, m_len, m_sdir, m_sshift, m_act, m_ph, m_cnt, m_tgt;

   tone_phase_gen dut (
      .clk_in          (clk),
      .reset_n_in      (rst_n),
      .tick_in         (tick),
      .frame_tick_in   (ftick),
      .reg_write_en_in (we),
      .reg_addr_in     (addr),
      .reg_data_in     (data),
      .lut_addr_out    (lut),
      .wave_type_out   (wave),
      .active_out      (act),
      .phase_wrap_out  (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got lut/wave/act/wrap=%h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_per = 0; m_wt = 0; m_len_en = 0; m_len = 0; m_sdir = 0; m_sshift = 0;
      m_act = 0; m_ph = 0; m_cnt = 0; m_tgt = 0;
   endtask

   // One cycle: drive inputs, advance the model, queue the expected outputs.
   task automatic cyc(input bit t, input bit f, input bit w, input int a, input int d);
      int np, nlen, nact, nph, ncnt, ntgt, nwrap, delta;
      exp_t e;
      @(negedge clk);
      tick = t; ftick = f; we = w; addr = a[1:0]; data = d[7:0];
      np = m_per; nlen = m_len; nact = m_act; nph = m_ph;
      ncnt = m_cnt; ntgt = m_tgt; nwrap = 0;
      // phase steps once every (period at last step)+1 ticks while active
      if (t && m_act != 0) begin
         if (m_cnt == m_tgt) begin
            nph = (m_ph + 1) % 32; nwrap = (m_ph == 31); ncnt = 0; ntgt = m_per;
         end else ncnt = m_cnt + 1;
      end
      if (f && m_act != 0) begin
         if (m_sshift != 0) begin
            delta = m_per >> m_sshift;
            if (m_sdir == 0) begin
               if (m_per + delta > 2047) nact = 0; else np = m_per + delta;
            end else np = m_per - delta;
         end
         if (m_len_en != 0 && m_len != 0) begin
            nlen = m_len - 1;
            if (nlen == 0) nact = 0;
         end
      end
      if (w) begin
         case (a)
            0: np = (m_per / 256) * 256 + (d % 256);
            1: begin
               np = (m_per % 256) + (d % 8) * 256;
               m_wt = (d / 8) % 8;
               m_len_en = (d / 64) % 2;
               if ((d / 128) % 2 == 1) begin
                  nact = 1; nph = 0; ncnt = 0; ntgt = np; nwrap = 0;
                  if (nlen == 0) nlen = 64;
               end
            end
            2: nlen = 64 - (d % 64);
            default: begin m_sdir = (d / 8) % 2; m_sshift = d % 8; end
         endcase
      end
      m_per = np; m_len = nlen; m_act = nact; m_ph = nph; m_cnt = ncnt; m_tgt = ntgt;
      e.lut = 5'(m_ph); e.wave = 3'(m_wt); e.act = 1'(m_act); e.wrap = 1'(nwrap);
      q.push_back(e);
   endtask

   task automatic async_reset();
      @(negedge clk);
      tick = 0; ftick = 0; we = 0;
      #2 rst_n = 0;
      #1 chk("async_reset", {lut, wave, act, wrap}, 10'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("outputs", {lut, wave, act, wrap}, e);
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", {lut, wave, act, wrap}, 10'h0);
      @(negedge clk);
      rst_n = 1;

      // period 3, wave 5, free-running ticks: phase every 4 ticks, wrap at 128
      cyc(0, 0, 1, 0, 3);
      cyc(0, 0, 1, 1, 8'hA8);
      repeat (140) cyc(1, 0, 0, 0, 0);

      // length 62 -> two frames then silence; ticks then frozen
      cyc(0, 0, 1, 2, 62);
      cyc(0, 0, 1, 1, 8'hE8);
      repeat (5) cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (20) cyc(1, 0, 0, 0, 0);

      // sweep add overflow at 0x700, then subtract to 0x380
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 3, 8'h01);
      cyc(0, 0, 1, 1, 8'hAF);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 8'h09);
      cyc(0, 0, 1, 1, 8'hAF);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 3, 8'h00);
      repeat (1900) cyc(1, 0, 0, 0, 0);

      // trigger coincident with a tick at phase 17
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 8'hA8);
      repeat (17) cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, 1, 8'hA8);
      repeat (3) cyc(1, 0, 0, 0, 0);

      // async reset with phase 9, ticks ignored until retrigger
      repeat (6) cyc(1, 0, 0, 0, 0);
      async_reset();
      repeat (10) cyc(1, 0, 0, 0, 0);

      // trigger with len_cnt 0 and len_en: 64 frames to expire
      cyc(0, 0, 1, 1, 8'hE8);
      for (int i = 0; i < 66; i++) begin
         cyc(1, 1, 0, 0, 0);
         cyc(1, 0, 0, 0, 0);
      end

      // randomised traffic
      for (int i = 0; i < 4000; i++) begin
         bit t, f, w;
         int a, d;
         t = ($urandom_range(3) != 0);
         f = ($urandom_range(15) == 0);
         w = ($urandom_range(7) == 0);
         a = $urandom_range(3);
         d = $urandom_range(255);
         if (a == 0 && $urandom_range(1) == 1) d = d % 8;
         if (a == 1 && $urandom_range(3) != 0) d = d - (d % 8);
         cyc(t, f, w, a, d);
         if ($urandom_range(999) == 0) async_reset();
      end

      repeat (3) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tone_phase_gen.md
# tone_phase_gen

Per-channel tone oscillator feeding the wave lookup stage of the sound generator. Holds the channel's register file (period, wave type, length, sweep), divides the prescaler tick by the programmed period, and steps a 5-bit phase that drives the lookup address and wave-type inputs of the wave lookup stage. A length counter and frequency sweep, clocked by a frame tick, gate the channel via `active_out`; the downstream mixer mutes on that signal.

## Interface
- `PERIOD_W`, 11, period/divider width
- `PHASE_W`, 5, phase width (32-step wave table)
- `LEN_W`, 6, length register width
- `clk_in`  in  1  system clock
- `reset_n_in`  in  1  reset; asynchronous and active-low
- `tick_in`  in  1  prescaler enable, 1-cycle pulse
- `frame_tick_in`  in  1  length/sweep enable, 1-cycle pulse
- `reg_write_en_in`  in  1  register write strobe
- `reg_addr_in`  in  2  register select
- `reg_data_in`  in  8  write data
- `lut_addr_out`  out  5  phase, to wave lookup address
- `wave_type_out`  out  3  to wave lookup type select
- `active_out`  out  1  channel sounding
- `phase_wrap_out`  out  1  1-cycle pulse on phase 31→0

## Operation
- Reg 0: `period[7:0]`.
- Reg 1: bit7 trigger (self-clearing, not stored), bit6 `len_en`, bits5:3 `wave_type`, bits2:0 `period[10:8]`.
- Reg 2: bits5:0 `len_load`. A write sets `len_cnt` (7 bit) to 64 − `len_load`, giving 1..64.
- Reg 3: bit3 `sweep_dir` (0 add, 1 sub), bits2:0 `sweep_shift`.
- Divider: on `tick_in` with `active`:
  - `div_cnt`==0: reload `div_cnt` = period and increment phase (mod 32). Phase therefore advances every period+1 ticks.
  - Otherwise decrement `div_cnt`.
  - Phase 31→0 asserts `phase_wrap_out` for the following cycle.
- Trigger, i.e. reg 1 written with bit7=1: `active`←1, phase←0, `div_cnt`←new period (same-write value). If `len_cnt`==0, `len_cnt`←64.
- Length: on `frame_tick_in`, if `active`, `len_en` and `len_cnt`≠0, decrement `len_cnt`. Reaching 0 clears `active`.
- Sweep: on `frame_tick_in`, if `active` and `sweep_shift`≠0:
  - delta = period >> shift.
  - Add: compute a 12-bit sum. If sum > 2047, clear `active` and leave period unchanged; otherwise period←sum.
  - Sub: period←period − delta. It cannot underflow.
- Inactive channel: phase and `div_cnt` frozen; `lut_addr_out` holds its last value.
- Priority within a cycle:
  - Trigger beats `tick_in`.
  - Reg writes beat sweep/length updates to the same field.
  - A trigger in the same cycle as a length expiry leaves `active`=1.
  - Sweep and length both act on the same `frame_tick_in`; either may clear `active`.

## Timing
- All outputs registered. Reset (async assert, sync-safe deassert) forces all state and outputs to 0: `lut_addr_out`=0, `wave_type_out`=0, `active_out`=0, `phase_wrap_out`=0, period=0, `len_cnt`=0.
- Latency:
  - Register write in cycle N is visible on outputs in N+1.
  - A `tick_in` in cycle N that steps the phase updates `lut_addr_out` in N+1.
- Reset mid-operation: the channel is silent immediately and ignores ticks until retriggered.
- `tick_in`/`frame_tick_in` assert for one cycle at a time. Back-to-back pulses are legal and each counts.

## Structure
- Shared package `sound_pkg`:
  - Register address constants `REG_PERIOD_LO`/`REG_CTRL`/`REG_LEN`/`REG_SWEEP`.
  - Bit-position constants for the ctrl and sweep fields.
  - Widths `PERIOD_W`, `PHASE_W`, `LEN_W`.
- One sub-module: `tone_sweep_calc`, combinational. Inputs: period, shift, dir. Outputs: next_period, overflow.
- Everything else (registers, divider, length counter) lives in the top.

## Test plan
- Period=3, wave_type=5, trigger, `tick_in` every cycle → `lut_addr_out` steps every 4 ticks; `phase_wrap_out` pulses once after 128 ticks; `wave_type_out`=5.
- `len_load`=62, `len_en`=1, trigger, 2 `frame_tick_in` → `active_out` falls the cycle after the 2nd; further ticks leave `lut_addr_out` frozen.
- Period=0x700, sweep add shift=1, one frame tick → sum 0xA80 > 2047, so `active_out`=0 and period stays 0x700. Same with sub → period 0x380.
- Trigger write coincident with `tick_in` while phase=17 → `lut_addr_out`=0 next cycle, no increment.
- Assert `reset_n_in` low mid-count with phase=9 → all outputs 0 asynchronously; after release, ticks have no effect until trigger.
- Trigger with `len_cnt`==0 and `len_en`=1 → 64 frame ticks needed before `active_out` clears.
